dt_event_timer: RTL and testbench
=================================

# dt_event_timer

- Upstream requester for `time_manager`.
- Holds the emulated time remaining until a programmed event and drives one `dt_req` lane so the global `emu_dt` never steps past that event.
- Each cycle it consumes the granted `emu_dt` and decrements the remaining time by it.
- Fires a one-cycle event pulse when the remaining time reaches exactly zero; supports one-shot and periodic modes.

## Interface
Parameters:
- `width`, 32: signed width of `dt_req`, `emu_dt` and `load_period`; matches `time_manager` `width`.
- `DT_MAX`, 2**(width-1)-1: request value driven when idle, and the cap on any request.
- `STAT_WIDTH`, 16: width of `event_count`.

Ports:
- `emu_clk`  in  1  emulator clock; single clock domain.
- `emu_rst`  in  1  reset, synchronous, active-high.
- `emu_dt`  in  width  granted timestep for this cycle, from `time_manager`.
- `load_valid`  in  1  program request.
- `load_ready`  out  1  program accept.
- `load_period`  in  width  event period; legal range 1..DT_MAX.
- `load_periodic`  in  1  1 = periodic, 0 = one-shot; sampled with the load.
- `cancel`  in  1  abort the timer and return to IDLE.
- `dt_req`  out  width  requested timestep, to one lane of `time_manager`.
- `event_pulse`  out  1  one-cycle registered event strobe.
- `active`  out  1  high in state COUNT.
- `err`  out  1  sticky protocol-error flag; cleared only by reset.
- `event_count`  out  STAT_WIDTH  saturating count of fired events (see Configuration).

## Operation
State and registers:
- States: IDLE, COUNT. Registers: `rem`, `period`, `periodic`.

Combinational outputs:
- `dt_req` = DT_MAX in IDLE; min(`rem`, DT_MAX) in COUNT.
- `load_ready` = !`emu_rst`.
- `active` = (state == COUNT).

Load handshake:
- A load is accepted when `load_valid` and `load_ready` are both high.
- On an accepted load with `load_period` in 1..DT_MAX:
  - `rem` <= `load_period`, `period` <= `load_period`, `periodic` <= `load_periodic`;
  - state -> COUNT;
  - the `emu_dt` of that cycle is discarded (not subtracted).
- On an accepted load with `load_period` <= 0: `err` <= 1, state -> IDLE, `rem` unchanged.

Priority within one cycle, highest first:
1. `emu_rst`
2. `cancel` (state -> IDLE, no event, even with a simultaneous load)
3. accepted load
4. countdown

Countdown (state COUNT, no cancel, no load):
- `emu_dt` < 0: `err` <= 1, `rem` unchanged.
- `emu_dt` = 0: no change.
- 0 < `emu_dt` < `rem`: `rem` <= `rem` - `emu_dt`.
- `emu_dt` = `rem`: event. `event_pulse` <= 1.
  - periodic: `rem` <= `period`, stay in COUNT.
  - one-shot: state -> IDLE.
- `emu_dt` > `rem`: overshoot, which breaks the min-grant guarantee.
  - `err` <= 1; treat as an event (same transitions as `emu_dt` = `rem`).

In IDLE, `emu_dt` is ignored.

Arithmetic:
- Subtraction and compares are signed, `width` bits.
- `rem` never goes negative and never wraps.

## Timing
- Reset values: state IDLE, `rem` 0, `period` 0, `periodic` 0, `event_pulse` 0, `err` 0, `event_count` 0.
- During reset: `dt_req` = DT_MAX, `load_ready` 0, `active` 0.
- Load accepted at edge k -> COUNT in cycle k+1 with `dt_req` = min(P, DT_MAX).
- Zero-hit in cycle t -> `event_pulse` high for cycle t+1 only.
- In periodic mode the reload happens at the same edge as the hit, so no cycle with `rem` = 0 exists.
  - Back-to-back pulses are possible when `emu_dt` = `period` every cycle.
- A reset asserted mid-count discards the pending event.
  - A pulse already scheduled for the next cycle is suppressed.

## Configuration
- `DT_EVENT_TIMER_STATS_EN` defined:
  - `event_count` increments on every `event_pulse`, saturating at 2**STAT_WIDTH-1;
  - reset to 0 by `emu_rst`.
- Not defined: `event_count` tied to 0, and the counter logic is not compiled in.

## Test plan
- Reset -> `dt_req` = DT_MAX, `active` 0, `event_pulse` 0, `err` 0, `load_ready` 0 during reset, then 1.
- One-shot P=10, bench drives `emu_dt` = min(`dt_req`, 4) -> `dt_req` sequence 10, 6, 2; `emu_dt` 4, 4, 2; `event_pulse` one cycle later; `active` 0 and `dt_req` = DT_MAX afterwards.
- Periodic P=3, `emu_dt` = `dt_req` -> `event_pulse` high every cycle from cycle 2 after load; `dt_req` stays 3.
- COUNT with `rem`=5, `emu_dt`=7 -> `err` 1 (sticky), `event_pulse` next cycle; separately, load with `load_period`=0 -> `err` 1, `active` 0.
- `rem`=8 with a load of P=20 -> `dt_req` = 20 next cycle, no event; same-cycle `cancel` + load -> IDLE, `dt_req` = DT_MAX.
- With `DT_EVENT_TIMER_STATS_EN`, STAT_WIDTH=2, periodic P=1, 5 events -> `event_count` 1, 2, 3, 3, 3; without the macro -> `event_count` 0 throughout.

Source files
------------

// File: rtl/dt_event_timer.sv
// Event timer: counts emulated time down to a programmed event and caps its dt_req lane.
// Optional saturating event counter compiled in with DT_EVENT_TIMER_STATS_EN.
module dt_event_timer #(
  parameter int                      width      = 32,
  parameter logic signed [width-1:0] DT_MAX     = {1'b0, {(width-1){1'b1}}},
  parameter int                      STAT_WIDTH = 16
) (
  input  logic                    emu_clk,
  input  logic                    emu_rst,
  input  logic signed [width-1:0] emu_dt,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic signed [width-1:0] load_period,
  input  logic                    load_periodic,
  input  logic                    cancel,
  output logic signed [width-1:0] dt_req,
  output logic                    event_pulse,
  output logic                    active,
  output logic                    err,
  output logic [STAT_WIDTH-1:0]   event_count
);

  typedef enum logic {StIdle, StCount} state_e;

  localparam logic signed [width-1:0] Zero = '0;

  state_e                  state_q, state_d;
  logic signed [width-1:0] rem_q, rem_d;
  logic signed [width-1:0] period_q, period_d;
  logic                    periodic_q, periodic_d;
  logic                    pulse_q, pulse_d;
  logic                    err_q, err_d;
  logic                    load_acc;

  assign load_ready  = !emu_rst;
  assign load_acc    = load_valid && load_ready;
  assign active      = (state_q == StCount);
  assign event_pulse = pulse_q;
  assign err         = err_q;

  always_comb begin
    dt_req = DT_MAX;
    if (state_q == StCount && rem_q < DT_MAX) dt_req = rem_q;
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    period_d   = period_q;
    periodic_d = periodic_q;
    pulse_d    = 1'b0;
    err_d      = err_q;
    if (cancel) begin
      state_d = StIdle;
    end else if (load_acc) begin
      // The emu_dt granted in the load cycle is deliberately not subtracted.
      if (load_period > Zero) begin
        rem_d      = load_period;
        period_d   = load_period;
        periodic_d = load_periodic;
        state_d    = StCount;
      end else begin
        err_d   = 1'b1;
        state_d = StIdle;
      end
    end else if (state_q == StCount) begin
      if (emu_dt < Zero) begin
        err_d = 1'b1;
      end else if (emu_dt != Zero) begin
        if (emu_dt < rem_q) begin
          rem_d = rem_q - emu_dt;
        end else begin
          // Overshoot is flagged but still fires, so rem never goes negative.
          if (emu_dt > rem_q) err_d = 1'b1;
          pulse_d = 1'b1;
          if (periodic_q) begin
            rem_d = period_q;
          end else begin
            rem_d   = Zero;
            state_d = StIdle;
          end
        end
      end
    end
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      period_q   <= '0;
      periodic_q <= 1'b0;
      pulse_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
      pulse_q    <= pulse_d;
      err_q      <= err_d;
    end
  end

`ifdef DT_EVENT_TIMER_STATS_EN
  logic [STAT_WIDTH-1:0] count_q, count_d;

  // Counts at the same edge that raises event_pulse, so the two stay aligned.
  always_comb begin
    count_d = count_q;
    if (pulse_d && (count_q != {STAT_WIDTH{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) count_q <= '0;
    else         count_q <= count_d;
  end

  assign event_count = count_q;
`else
  assign event_count = '0;
`endif

endmodule

// File: tb/tb_dt_event_timer.sv
// Scoreboarded bench for dt_event_timer: each row holds expected outputs and the next stimulus.
module tb_dt_event_timer;

  localparam int W  = 32;
  localparam int SW = 2;
  localparam logic signed [W-1:0] DTM = {1'b0, {(W-1){1'b1}}};

  logic                emu_clk = 1'b0;
  logic                emu_rst;
  logic signed [W-1:0] emu_dt;
  logic                load_valid;
  logic                load_ready;
  logic signed [W-1:0] load_period;
  logic                load_periodic;
  logic                cancel;
  logic signed [W-1:0] dt_req;
  logic                event_pulse;
  logic                active;
  logic                err;
  logic [SW-1:0]       event_count;

  dt_event_timer #(
    .width     (W),
    .STAT_WIDTH(SW)
  ) dut (
    .emu_clk      (emu_clk),
    .emu_rst      (emu_rst),
    .emu_dt       (emu_dt),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_period  (load_period),
    .load_periodic(load_periodic),
    .cancel       (cancel),
    .dt_req       (dt_req),
    .event_pulse  (event_pulse),
    .active       (active),
    .err          (err),
    .event_count  (event_count)
  );

  always #5 emu_clk = ~emu_clk;

  typedef struct {
    logic signed [W-1:0] dt;
    logic                pulse;
    logic                act;
    logic                er;
    logic [SW-1:0]       cnt;
    logic signed [W-1:0] dti;
    logic                lv;
    logic signed [W-1:0] lp;
    logic                per;
    logic                can;
    logic                rst;
  } step_t;

  step_t q[$];
  step_t s;
  int    n_pass  = 0;
  int    n_total = 0;

  function automatic step_t mk(input logic signed [W-1:0] dt, input logic pulse,
                               input logic act, input logic er, input int dti, input logic lv,
                               input int lp, input logic per, input logic can, input logic rst);
    step_t r;
    r.dt = dt; r.pulse = pulse; r.act = act; r.er = er; r.cnt = '0;
    r.dti = dti; r.lv = lv; r.lp = lp; r.per = per; r.can = can; r.rst = rst;
    return r;
  endfunction

  function automatic logic [SW-1:0] sat_cnt(input int n);
`ifdef DT_EVENT_TIMER_STATS_EN
    return (n > 3) ? 2'd3 : n[SW-1:0];
`else
    return (n > 0) ? 2'd0 : 2'd0;
`endif
  endfunction

  task automatic apply(input step_t r);
    emu_dt        = r.dti;
    load_valid    = r.lv;
    load_period   = r.lp;
    load_periodic = r.per;
    cancel        = r.can;
    emu_rst       = r.rst;
  endtask

  task automatic do_reset;
    apply(mk(DTM, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge emu_clk);
    emu_rst = 1'b0;
  endtask

  task automatic test_reset;
    apply(mk(DTM, 0, 0, 0, 0, 1, 5, 0, 0, 1));
    repeat (2) @(negedge emu_clk);
    n_total += 5;
    if (dt_req !== DTM) $display("FAIL rst_dt_req: got %0d want %0d", dt_req, DTM);
    else n_pass++;
    if (active !== 1'b0) $display("FAIL rst_active: got %b want 0", active);
    else n_pass++;
    if (event_pulse !== 1'b0) $display("FAIL rst_pulse: got %b want 0", event_pulse);
    else n_pass++;
    if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err);
    else n_pass++;
    if (load_ready !== 1'b0) $display("FAIL rst_load_ready: got %b want 0", load_ready);
    else n_pass++;
    load_valid = 1'b0;
    emu_rst    = 1'b0;
    #1;
    n_total++;
    if (load_ready !== 1'b1) $display("FAIL post_rst_load_ready: got %b want 1", load_ready);
    else n_pass++;
    @(negedge emu_clk);
  endtask

  task automatic test_oneshot;
    int row = 0;
    do_reset();
    q.push_back(mk(DTM, 0, 0, 0, 0, 1, 10, 0, 0, 0));
    q.push_back(mk(10, 0, 1, 0, 4, 0, 0, 0, 0, 0));
    q.push_back(mk(6, 0, 1, 0, 4, 0, 0, 0, 0, 0));
    q.push_back(mk(2, 0, 1, 0, 2, 0, 0, 0, 0, 0));
    q.push_back(mk(DTM, 1, 0, 0, 4, 0, 0, 0, 0, 0));
    q.push_back(mk(DTM, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    while (q.size() != 0) begin
      s = q.pop_front();
      n_total++;
      if (dt_req !== s.dt || event_pulse !== s.pulse || active !== s.act || err !== s.er)
        $display("FAIL oneshot row%0d: got dt_req=%0d pulse=%b active=%b err=%b want %0d %b %b %b",
                 row, dt_req, event_pulse, active, err, s.dt, s.pulse, s.act, s.er);
      else n_pass++;
      apply(s);
      @(negedge emu_clk);
      row++;
    end
  endtask

  task automatic test_periodic;
    int row = 0;
    do_reset();
    q.push_back(mk(DTM, 0, 0, 0, 0, 1, 3, 1, 0, 0));
    q.push_back(mk(3, 0, 1, 0, 3, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) q.push_back(mk(3, 1, 1, 0, 3, 0, 0, 0, 0, 0));
    q.push_back(mk(3, 1, 1, 0, 3, 0, 0, 0, 1, 0));
    q.push_back(mk(DTM, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    while (q.size() != 0) begin
      s = q.pop_front();
      n_total++;
      if (dt_req !== s.dt || event_pulse !== s.pulse || active !== s.act || err !== s.er)
        $display("FAIL periodic row%0d: got dt_req=%0d pulse=%b active=%b err=%b want %0d %b %b %b",
                 row, dt_req, event_pulse, active, err, s.dt, s.pulse, s.act, s.er);
      else n_pass++;
      apply(s);
      @(negedge emu_clk);
      row++;
    end
  endtask

  task automatic test_error;
    int row = 0;
    do_reset();
    q.push_back(mk(DTM, 0, 0, 0, 0, 1, 5, 0, 0, 0));
    q.push_back(mk(5, 0, 1, 0, 7, 0, 0, 0, 0, 0));      // overshoot
    q.push_back(mk(DTM, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(DTM, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(DTM, 0, 0, 0, 0, 1, 6, 0, 0, 0));
    q.push_back(mk(6, 0, 1, 0, -1, 0, 0, 0, 0, 0));     // negative grant
    q.push_back(mk(6, 0, 1, 1, 6, 0, 0, 0, 0, 0));
    q.push_back(mk(DTM, 1, 0, 1, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(DTM, 0, 0, 0, 0, 1, 9, 0, 0, 0));
    q.push_back(mk(9, 0, 1, 0, 0, 1, 0, 0, 0, 0));      // zero-period load
    q.push_back(mk(DTM, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(DTM, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    while (q.size() != 0) begin
      s = q.pop_front();
      n_total++;
      if (dt_req !== s.dt || event_pulse !== s.pulse || active !== s.act || err !== s.er)
        $display("FAIL error row%0d: got dt_req=%0d pulse=%b active=%b err=%b want %0d %b %b %b",
                 row, dt_req, event_pulse, active, err, s.dt, s.pulse, s.act, s.er);
      else n_pass++;
      apply(s);
      @(negedge emu_clk);
      row++;
    end
  endtask

  task automatic test_reload_cancel;
    int row = 0;
    do_reset();
    q.push_back(mk(DTM, 0, 0, 0, 0, 1, 12, 0, 0, 0));
    q.push_back(mk(12, 0, 1, 0, 4, 0, 0, 0, 0, 0));
    q.push_back(mk(8, 0, 1, 0, 8, 1, 20, 0, 0, 0));     // reload beats a hit
    q.push_back(mk(20, 0, 1, 0, 20, 1, 7, 0, 1, 0));    // cancel beats load
    q.push_back(mk(DTM, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(DTM, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    while (q.size() != 0) begin
      s = q.pop_front();
      n_total++;
      if (dt_req !== s.dt || event_pulse !== s.pulse || active !== s.act || err !== s.er)
        $display("FAIL reload row%0d: got dt_req=%0d pulse=%b active=%b err=%b want %0d %b %b %b",
                 row, dt_req, event_pulse, active, err, s.dt, s.pulse, s.act, s.er);
      else n_pass++;
      apply(s);
      @(negedge emu_clk);
      row++;
    end
  endtask

  task automatic test_midcount_reset;
    int row = 0;
    do_reset();
    q.push_back(mk(DTM, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    q.push_back(mk(2, 0, 1, 0, 2, 0, 0, 0, 0, 1));      // hit and reset together
    q.push_back(mk(DTM, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    q.push_back(mk(2, 0, 1, 0, 2, 0, 0, 0, 0, 0));
    q.push_back(mk(DTM, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(DTM, 0, 0, 0, -3, 0, 0, 0, 0, 0));   // idle ignores emu_dt
    q.push_back(mk(DTM, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    while (q.size() != 0) begin
      s = q.pop_front();
      n_total++;
      if (dt_req !== s.dt || event_pulse !== s.pulse || active !== s.act || err !== s.er)
        $display("FAIL midrst row%0d: got dt_req=%0d pulse=%b active=%b err=%b want %0d %b %b %b",
                 row, dt_req, event_pulse, active, err, s.dt, s.pulse, s.act, s.er);
      else n_pass++;
      apply(s);
      @(negedge emu_clk);
      row++;
    end
  endtask

  task automatic test_stats;
    int row = 0;
    do_reset();
    s = mk(DTM, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    s.cnt = sat_cnt(0);
    q.push_back(s);
    s = mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    s.cnt = sat_cnt(0);
    q.push_back(s);
    for (int i = 1; i <= 5; i++) begin
      s = mk(1, 1, 1, 0, 1, 0, 0, 0, (i == 5), 0);
      s.cnt = sat_cnt(i);
      q.push_back(s);
    end
    s = mk(DTM, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    s.cnt = sat_cnt(5);
    q.push_back(s);
    while (q.size() != 0) begin
      s = q.pop_front();
      n_total++;
      if (dt_req !== s.dt || event_pulse !== s.pulse || active !== s.act ||
          event_count !== s.cnt)
        $display("FAIL stats row%0d: got dt_req=%0d pulse=%b active=%b cnt=%0d want %0d %b %b %0d",
                 row, dt_req, event_pulse, active, event_count, s.dt, s.pulse, s.act, s.cnt);
      else n_pass++;
      apply(s);
      @(negedge emu_clk);
      row++;
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_error();
    test_reload_cancel();
    test_midcount_reset();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
